// File: rtl/uc_stall_ctrl_pkg.sv
// uc_stall_ctrl_pkg: shared microinstruction constants and scoreboard entry type
package uc_stall_ctrl_pkg;
    localparam logic [5:0] REG_NONE = 6'd0;
    localparam logic [1:0] M_NONE   = 2'b00;
    localparam logic [1:0] M_READ   = 2'b01;
    localparam logic [1:0] M_WRITE  = 2'b10;
    typedef struct packed {
        logic [5:0] dest;
        logic [1:0] m;
    } sb_entry_t;
    localparam sb_entry_t NOP_ENTRY = '{dest: REG_NONE, m: M_NONE};
    function automatic logic is_mem(input logic [1:0] m);
        return m == M_READ || m == M_WRITE;
    endfunction
endpackage

// File: rtl/uc_stall_ctrl_if.sv
// uc_stall_ctrl_if: decode-stage interlock signals between decode and the stall controller
interface uc_stall_ctrl_if;
    logic [5:0]  busA_id;
    logic [5:0]  busB_id;
    logic [5:0]  busC_id;
    logic [1:0]  M_id;
    logic        MEM_ACK;
    logic        HOLD;
    logic        FREEZE;
    logic        BUS_ERR;
    logic [15:0] stall_cnt;
    modport master (output busA_id, busB_id, busC_id, M_id, MEM_ACK,
                    input HOLD, FREEZE, BUS_ERR, stall_cnt);
    modport slave  (input busA_id, busB_id, busC_id, M_id, MEM_ACK,
                    output HOLD, FREEZE, BUS_ERR, stall_cnt);
endinterface

// File: rtl/uc_mem_wait_fsm.sv
// uc_mem_wait_fsm: freezes the pipeline while a memory op at MEM_STAGE awaits its ack
module uc_mem_wait_fsm
    import uc_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       mem_ack_i,
    input  logic [1:0] mem_m_i,
    output logic       freeze_o,
    output logic       bus_err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freeze_o = 1'b0;
        case (state_q)
            S_IDLE: if (is_mem(mem_m_i) && !mem_ack_i) begin
                state_d  = S_WAIT;
                cnt_d    = '0;
                freeze_o = 1'b1;
            end
            S_WAIT: if (mem_ack_i) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                freeze_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = cnt_d == CW'(TIMEOUT) ? S_ERR : S_WAIT;
            end
            default: freeze_o = 1'b1;
        endcase
    end
    assign bus_err_o = state_q == S_ERR;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/uc_stall_ctrl.sv
// uc_stall_ctrl: RAW scoreboard plus memory-wait freeze driving NOP injection at decode
module uc_stall_ctrl
    import uc_stall_ctrl_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int MEM_STAGE = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic          CLK,
    input  logic          RST,
    uc_stall_ctrl_if.slave bus
);
    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [15:0] cnt_q;
    logic hazard, hold, freeze, bus_err;
    uc_mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .CLK       (CLK),
        .RST       (RST),
        .mem_ack_i (bus.MEM_ACK),
        .mem_m_i   (sb_q[MEM_STAGE].m),
        .freeze_o  (freeze),
        .bus_err_o (bus_err)
    );
    // the oldest entry still hazards: register file writes at end of cycle, no bypass
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hazard |= (bus.busA_id != REG_NONE && bus.busA_id == sb_q[i].dest) ||
                      (bus.busB_id != REG_NONE && bus.busB_id == sb_q[i].dest);
    end
    assign hold = hazard | freeze;
    always_comb begin
        sb_d = sb_q;
        if (!freeze) begin
            sb_d[0] = hold ? NOP_ENTRY : {bus.busC_id, bus.M_id};
            for (int i = 1; i < DEPTH; i++) sb_d[i] = sb_q[i-1];
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= (hold && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        end
    end
    assign bus.HOLD      = hold;
    assign bus.FREEZE    = freeze;
    assign bus.BUS_ERR   = bus_err;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_uc_stall_ctrl.sv
// tb_uc_stall_ctrl: directed vector table plus multi-cycle memory-wait sequences
module tb_uc_stall_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int errors = 0;
    uc_stall_ctrl_if bus ();
    uc_stall_ctrl #(.DEPTH(3), .MEM_STAGE(1), .TIMEOUT(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  a, b, c;
        logic [1:0]  m;
        logic        ack, hold, frz, err;
        logic [15:0] cnt;
    } vec_t;
    vec_t vt [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [5:0] a, b, c, input logic [1:0] m,
                        input logic ack, hold, frz, err, input logic [15:0] cnt);
        bus.busA_id = a;
        bus.busB_id = b;
        bus.busC_id = c;
        bus.M_id    = m;
        bus.MEM_ACK = ack;
        @(negedge CLK);
        chk({nm, ".hold"}, 32'(bus.HOLD), 32'(hold));
        chk({nm, ".freeze"}, 32'(bus.FREEZE), 32'(frz));
        chk({nm, ".bus_err"}, 32'(bus.BUS_ERR), 32'(err));
        chk({nm, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(cnt));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        bus.busA_id = '0; bus.busB_id = '0; bus.busC_id = '0; bus.M_id = '0; bus.MEM_ACK = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        //          a   b   c   m  ack hold frz err cnt
        vt[0]  = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vt[1]  = '{6'd0, 6'd0, 6'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vt[2]  = '{6'd5, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vt[3]  = '{6'd5, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        vt[4]  = '{6'd5, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
        vt[5]  = '{6'd5, 6'd0, 6'd7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        vt[6]  = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        vt[7]  = '{6'd0, 6'd7, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};
        vt[8]  = '{6'd0, 6'd7, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4};
        vt[9]  = '{6'd0, 6'd7, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[10] = '{6'd0, 6'd0, 6'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[11] = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[12] = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[13] = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[14] = '{6'd0, 6'd0, 6'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[15] = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[16] = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[17] = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[18] = '{6'd63, 6'd0, 6'd63, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        vt[19] = '{6'd0, 6'd63, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5};
        vt[20] = '{6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd6};

        do_reset();
        for (int i = 0; i < 21; i++)
            step($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].c, vt[i].m,
                 vt[i].ack, vt[i].hold, vt[i].frz, vt[i].err, vt[i].cnt);

        // read op acked after four frozen cycles; scoreboard must not move while frozen
        do_reset();
        step("rd_issue", 6'd0, 6'd0, 6'd9, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        step("rd_next",  6'd0, 6'd0, 6'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("rd_frz%0d", k), (k == 1) ? 6'd4 : 6'd0, 6'd0,
                 (k == 2) ? 6'd11 : 6'd0, (k == 2) ? 2'd1 : 2'd0,
                 1'b0, 1'b1, 1'b1, 1'b0, 16'(k));
            chk($sformatf("rd_sb%0d", k), 32'(dut.sb_q), 32'h002510);
        end
        step("rd_ack", 6'd0, 6'd0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
        chk("rd_sb_shift", 32'(dut.sb_q), 32'h251000);
        step("rd_after", 6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);

        // never-acked op: 8 WAIT cycles then sticky ERR, then saturation
        do_reset();
        step("to_issue", 6'd0, 6'd0, 6'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        step("to_next",  6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 9; k++)
            step($sformatf("to_wait%0d", k), 6'd0, 6'd0, 6'd0, 2'd0, 1'b0,
                 1'b1, 1'b1, 1'b0, 16'(k));
        step("to_err",    6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd9);
        step("to_errack", 6'd0, 6'd0, 6'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd10);
        bus.MEM_ACK = 1'b0;
        repeat (70000) @(posedge CLK);
        #1;
        step("sat", 6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        do_reset();
        step("rst_clear", 6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // reset while in WAIT discards the in-flight op
        step("mw_issue", 6'd0, 6'd0, 6'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        step("mw_next",  6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        step("mw_idle",  6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        RST = 1'b1;
        step("mw_wait",  6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
        RST = 1'b0;
        step("mw_after", 6'd3, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("mw_sb_empty", 32'(dut.sb_q), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
